// File: rtl/lut_config_loader_if.sv
// Handshake/bus bundle between the top-level controller and lut_config_loader.
// o_parity_err exists only when LUT_CFG_PARITY_EN is defined.
interface lut_config_loader_if #(
  parameter int AW = 4
);
  logic          i_start;
  logic          i_bit;
  logic          i_bit_valid;
  logic          i_abort;
  logic [AW-1:0] o_addr;
  logic          o_data;
  logic          o_cfg_en;
  logic          o_busy;
  logic          o_done;
`ifdef LUT_CFG_PARITY_EN
  logic          o_parity_err;
`endif

  modport master (
    output i_start, i_bit, i_bit_valid, i_abort,
`ifdef LUT_CFG_PARITY_EN
    input  o_parity_err,
`endif
    input  o_addr, o_data, o_cfg_en, o_busy, o_done
  );

  modport slave (
    input  i_start, i_bit, i_bit_valid, i_abort,
`ifdef LUT_CFG_PARITY_EN
    output o_parity_err,
`endif
    output o_addr, o_data, o_cfg_en, o_busy, o_done
  );
endinterface

// File: rtl/lut_config_loader.sv
// Serial truth-table loader for a LUT cell: shift in LUT_BITS bits, then write them out.
// Optional trailing even-parity bit when LUT_CFG_PARITY_EN is defined.
module lut_config_loader #(
  parameter int LUT_BITS    = 16,
  parameter int HOLD_CYCLES = 1
) (
  input logic               clk,
  input logic               rst,
  lut_config_loader_if.slave bus
);
  localparam int AW = $clog2(LUT_BITS);
  localparam int CW = $clog2(LUT_BITS + 2);
  localparam int HW = 4;

  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_SETUP, S_STROBE, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [LUT_BITS-1:0]   shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  data_q, data_d;
  logic                  cfg_en_q, cfg_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef LUT_CFG_PARITY_EN
  logic                  parity_err_q, parity_err_d;
`endif

  // NOTE: every flop, including the shift register, is cleared by the async reset and
  // updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      hold_q   <= '0;
      addr_q   <= '0;
      data_q   <= 1'b0;
      cfg_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef LUT_CFG_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cfg_en_q <= cfg_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef LUT_CFG_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // NOTE: each combinational output gets a default before the case, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
`ifdef LUT_CFG_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_start && !bus.i_abort) begin
          state_d = S_SHIFT;
          shift_d = '0;
          cnt_d   = '0;
`ifdef LUT_CFG_PARITY_EN
          parity_err_d = 1'b0;
`endif
        end
      end
      S_SHIFT: begin
        if (bus.i_bit_valid) begin
`ifdef LUT_CFG_PARITY_EN
          // The extra bit after the table is parity and never enters the shift register.
          if (cnt_q == CW'(LUT_BITS)) begin
            if (bus.i_bit != ^shift_q) begin
              state_d      = S_IDLE;
              parity_err_d = 1'b1;
            end else begin
              state_d = S_SETUP;
              idx_d   = '0;
            end
          end else begin
            shift_d = {shift_q[LUT_BITS-2:0], bus.i_bit};
            cnt_d   = cnt_q + 1'b1;
          end
`else
          shift_d = {shift_q[LUT_BITS-2:0], bus.i_bit};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(LUT_BITS - 1)) begin
            state_d = S_SETUP;
            idx_d   = '0;
          end
`endif
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        hold_d  = '0;
      end
      S_STROBE: begin
        if (hold_q == HW'(HOLD_CYCLES - 1)) begin
          if (idx_q == AW'(LUT_BITS - 1)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_SETUP;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.i_abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    cfg_en_d = (state_d == S_STROBE);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    if (state_d == S_SETUP) begin
      addr_d = idx_d;
      data_d = shift_d[idx_d];
    end
  end

  assign bus.o_addr   = addr_q;
  assign bus.o_data   = data_q;
  assign bus.o_cfg_en = cfg_en_q;
  assign bus.o_busy   = busy_q;
  assign bus.o_done   = done_q;
`ifdef LUT_CFG_PARITY_EN
  assign bus.o_parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_lut_config_loader.sv
// Randomized self-checking bench for lut_config_loader against a phase-level trace model.
module tb_lut_config_loader;
  localparam int LB = 16;
  localparam int HC = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lut_config_loader_if #(.AW(4)) bus ();
  lut_config_loader #(.LUT_BITS(LB), .HOLD_CYCLES(HC)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [3:0] addr;
    logic       data;
    logic       cfg;
    logic       done;
  } exp_t;

  exp_t        trace[$];
  int          m_mode;   // 0 idle, 1 collecting bits, 2 replaying the write trace
  logic [15:0] m_tt;
  int          m_n;
  logic [3:0]  e_addr;
  logic        e_data, e_cfg, e_busy, e_done, e_perr, e_ad;

  function automatic void model_reset();
    trace.delete();
    m_mode = 0; m_tt = '0; m_n = 0;
    e_addr = '0; e_data = 1'b0; e_cfg = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    e_perr = 1'b0; e_ad = 1'b1;
  endfunction

  function automatic void go_idle();
    trace.delete();
    m_mode = 0;
    e_cfg = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_ad = 1'b0;
  endfunction

  function automatic void pop_trace();
    exp_t x;
    if (trace.size() == 0) begin
      go_idle();
    end else begin
      x = trace.pop_front();
      e_addr = x.addr; e_data = x.data; e_cfg = x.cfg; e_done = x.done;
      e_busy = 1'b1; e_ad = 1'b1;
    end
  endfunction

  // Every entry: one setup cycle, HC enable cycles; then one done cycle.
  function automatic void enter_write();
    trace.delete();
    for (int k = 0; k < LB; k++) begin
      trace.push_back('{addr: 4'(k), data: m_tt[k], cfg: 1'b0, done: 1'b0});
      for (int h = 0; h < HC; h++)
        trace.push_back('{addr: 4'(k), data: m_tt[k], cfg: 1'b1, done: 1'b0});
    end
    trace.push_back('{addr: 4'(LB - 1), data: m_tt[LB-1], cfg: 1'b0, done: 1'b1});
    m_mode = 2;
    pop_trace();
  endfunction

  function automatic void model_step(input logic s, input logic b, input logic v, input logic a);
    case (m_mode)
      0: if (s && !a) begin
           m_mode = 1; m_n = 0; m_tt = '0; e_busy = 1'b1; e_perr = 1'b0;
         end
      1: if (a) go_idle();
         else if (v) begin
           if (m_n < LB) begin
             m_tt = {m_tt[14:0], b};
             m_n++;
`ifndef LUT_CFG_PARITY_EN
             if (m_n == LB) enter_write();
`endif
           end
`ifdef LUT_CFG_PARITY_EN
           else if (b != ^m_tt) begin
             go_idle();
             e_perr = 1'b1;
           end else enter_write();
`endif
         end
      default: if (a) go_idle(); else pop_trace();
    endcase
  endfunction

  // ---------------- compare / observe ----------------
  bit          chk_en = 1'b0;
  logic        prev_cfg = 1'b0;
  logic [15:0] obs;
  int          strobes = 0;
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("cfg_en", int'(bus.o_cfg_en), int'(e_cfg));
      check("busy",   int'(bus.o_busy),   int'(e_busy));
      check("done",   int'(bus.o_done),   int'(e_done));
      if (e_ad) begin
        check("addr", int'(bus.o_addr), int'(e_addr));
        check("data", int'(bus.o_data), int'(e_data));
      end
`ifdef LUT_CFG_PARITY_EN
      check("parity_err", int'(bus.o_parity_err), int'(e_perr));
`endif
      if (bus.o_cfg_en) begin
        obs[bus.o_addr] = bus.o_data;
        if (!prev_cfg) strobes++;
      end
      prev_cfg = bus.o_cfg_en;
      if (bus.o_done) done_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic s, input logic b, input logic v, input logic a);
    bus.i_start = s; bus.i_bit = b; bus.i_bit_valid = v; bus.i_abort = a;
    @(posedge clk);
    model_step(s, b, v, a);
    #1;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'(($urandom)), 1'b0, 1'b0);
  endtask

  // Start, then send LB bits MSB first (plus parity if enabled); abort_at >= 0 aborts before that bit.
  task automatic load(input logic [15:0] tt, input int max_stall, input logic par, input int abort_at);
    obs = '0; strobes = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = LB - 1; i >= 0; i--) begin
      int st = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
      for (int j = 0; j < st; j++) drive(1'(($urandom % 4) == 0), 1'b0, 1'b0, 1'b0);
      if (i == abort_at) begin
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        return;
      end
      drive(1'b0, tt[i], 1'b1, 1'b0);
    end
`ifdef LUT_CFG_PARITY_EN
    drive(1'b0, par, 1'b1, 1'b0);
`else
    if (par !== 1'bx) begin end
`endif
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.o_busy && n < 200) begin idle_cycle(); n++; end
    check("wait_idle_timeout", int'(bus.o_busy), 0);
  endtask

  task automatic wait_write(input int addr, input logic need_cfg);
    int n = 0;
    while (!(bus.o_addr == 4'(addr) && (bus.o_cfg_en || !need_cfg) && bus.o_busy) && n < 200) begin
      idle_cycle(); n++;
    end
    check("wait_write_timeout", int'(n < 200), 1);
  endtask

  initial begin
    int lat;
    int dc;
    logic [15:0] tt;
    bus.i_start = 1'b0; bus.i_bit = 1'b0; bus.i_bit_valid = 1'b0; bus.i_abort = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Reset then idle
    check("rst_cfg_en", int'(bus.o_cfg_en), 0);
    check("rst_busy",   int'(bus.o_busy),   0);
    check("rst_addr",   int'(bus.o_addr),   0);
    repeat (20) idle_cycle();
    check("idle_busy", int'(bus.o_busy), 0);

    // Abort wins over start in idle
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    check("start_abort_idle", int'(bus.o_busy), 0);

    // AND4, contiguous bits
    load(16'h8000, 0, 1'b1, -1);
    lat = 0;
    while (!bus.o_done && lat < 100) begin idle_cycle(); lat++; end
    check("and4_latency", lat, 32);
    idle_cycle();
    check("and4_cfg_after", int'(bus.o_cfg_en), 0);
    check("and4_word", int'(obs), 32'h8000);
    check("and4_strobes", strobes, 16);
    check("and4_done_cnt", done_cnt, 1);

    // Stalled shift of XOR4
    obs = '0; strobes = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = LB - 1; i >= 0; i--) begin
      tt = 16'h6996;
      repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, tt[i], 1'b1, 1'b0);
    end
`ifdef LUT_CFG_PARITY_EN
    drive(1'b0, 1'b0, 1'b1, 1'b0);
`endif
    wait_idle();
    check("xor4_word", int'(obs), 32'h6996);
    check("xor4_strobes", strobes, 16);
    check("xor4_done_cnt", done_cnt, 2);

    // Abort during the strobe of addr 5
    dc = done_cnt;
    load(16'hA5C3, 1, ^16'hA5C3, -1);
    wait_write(5, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("abort_cfg_en", int'(bus.o_cfg_en), 0);
    check("abort_busy",   int'(bus.o_busy),   0);
    repeat (5) idle_cycle();
    check("abort_no_done", done_cnt, dc);
    check("abort_strobes", strobes, 6);

    // Start while busy at addr 8
    load(16'h1234, 2, ^16'h1234, -1);
    wait_write(8, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    wait_idle();
    repeat (3) idle_cycle();
    check("busy_start_done_cnt", done_cnt, dc + 1);
    check("busy_start_word", int'(obs), 32'h1234);

    // Randomized loads, one aborted mid-shift
    for (int r = 0; r < 8; r++) begin
      tt = 16'($urandom);
      load(tt, 3, ^tt, (r == 5) ? int'($urandom_range(LB - 1, 0)) : -1);
      wait_idle();
      repeat (int'($urandom_range(4, 0))) idle_cycle();
    end

`ifdef LUT_CFG_PARITY_EN
    load(16'h0001, 0, 1'b0, -1);
    repeat (3) idle_cycle();
    check("par_bad_err", int'(bus.o_parity_err), 1);
    check("par_bad_strobes", strobes, 0);
    load(16'h0001, 0, 1'b1, -1);
    wait_idle();
    check("par_good_err", int'(bus.o_parity_err), 0);
    check("par_good_word", int'(obs), 1);
`endif

    // Asynchronous reset mid-write drops the enable without a clock edge
    load(16'hFFFF, 0, 1'b0, -1);
    wait_write(3, 1'b1);
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst_cfg_en", int'(bus.o_cfg_en), 0);
    check("async_rst_busy",   int'(bus.o_busy),   0);
    check("async_rst_addr",   int'(bus.o_addr),   0);
    model_reset();
    prev_cfg = 1'b0;
    bus.i_start = 1'b0; bus.i_bit_valid = 1'b0; bus.i_abort = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    load(16'h00F0, 1, ^16'h00F0, -1);
    wait_idle();
    check("post_rst_word", int'(obs), 32'h00F0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
